// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
// Holds FSM encoding, requester IDs and default geometry constants.
package dmem_arb_pkg;

  typedef enum logic {
    NORMAL = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  typedef enum logic {
    CORE = 1'b0,
    DBG  = 1'b1
  } req_id_e;

  localparam int unsigned DEF_WORDS    = 64;
  localparam int unsigned DEF_MAX_LOCK = 16;

endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin picker.
// req[0]=core, req[1]=debug; last=ID of previous winner; gnt one-hot.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // On contention the side that did not win last time goes first.
  assign gnt[0] = req[0] & (~req[1] | (last == DBG));
  assign gnt[1] = req[1] & (~req[0] | (last == CORE));

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/debug arbiter in front of a 1-cycle-latency memory.
// Ports: clk, reset, core c_*, debug d_* (with d_lock), memory m_*.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WORDS    = DEF_WORDS,
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_lock,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  if (WORDS < 1 || MAX_LOCK < 1) begin : g_bad_param
    $error("dmem_arbiter: WORDS and MAX_LOCK must be >= 1");
  end

  arb_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic        last_q;
  logic        c_rv_q;
  logic        d_rv_q;
  logic [31:0] c_hold_q;
  logic [31:0] d_hold_q;

  logic [1:0]  rr_gnt;
  logic        force_c;
  logic        cg;
  logic        dg;

  dmem_rr_pick u_rr (
    .req  ({d_req, c_req}),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  // Starved core gets one slot once debug has had MAX_LOCK grants.
  assign force_c = (state_q == LOCKED) && c_req &&
                   (cnt_q == CW'(MAX_LOCK));

  always_comb begin
    cg = 1'b0;
    dg = 1'b0;
    if (!reset) begin
      unique case (1'b1)
        (state_q == NORMAL): begin
          cg = rr_gnt[0];
          dg = rr_gnt[1];
        end
        force_c: cg = 1'b1;
        default: dg = d_req;
      endcase
    end
  end

  assign c_gnt   = cg;
  assign d_gnt   = dg;
  assign m_we    = (cg & c_we) | (dg & d_we);
  assign m_addr  = cg ? c_addr  : (dg ? d_addr  : 32'h0);
  assign m_wdata = cg ? c_wdata : (dg ? d_wdata : 32'h0);

  // Response is live memory data in the rvalid cycle, held after.
  assign c_rvalid = c_rv_q & ~reset;
  assign d_rvalid = d_rv_q & ~reset;
  assign c_rdata  = reset ? 32'h0 : (c_rv_q ? m_rdata : c_hold_q);
  assign d_rdata  = reset ? 32'h0 : (d_rv_q ? m_rdata : d_hold_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NORMAL;
      cnt_q    <= '0;
      last_q   <= DBG;
      c_rv_q   <= 1'b0;
      d_rv_q   <= 1'b0;
      c_hold_q <= 32'h0;
      d_hold_q <= 32'h0;
    end else begin
      c_rv_q <= cg & ~c_we;
      d_rv_q <= dg & ~d_we;
      if (c_rv_q) c_hold_q <= m_rdata;
      if (d_rv_q) d_hold_q <= m_rdata;
      if (cg) last_q <= CORE;
      else if (dg) last_q <= DBG;
      unique case (state_q)
        NORMAL: begin
          cnt_q <= '0;
          if (dg && d_lock) state_q <= LOCKED;
        end
        LOCKED: begin
          if (!d_lock) begin
            state_q <= NORMAL;
            cnt_q   <= '0;
          end else if (!c_req || force_c) begin
            cnt_q <= '0;
          end else if (dg) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus lock/reset sequences, with a
// read-response scoreboard and a behavioural 1-cycle memory.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int WORDS    = 64;
  localparam int MAX_LOCK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        c_req, c_we, c_gnt, c_rvalid;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        d_req, d_we, d_lock, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  dmem_arbiter #(.WORDS(WORDS), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr),
    .c_wdata(c_wdata), .c_gnt(c_gnt),
    .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 ^ 32'(i * 4);
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % 32'(WORDS));
  endfunction

  logic [31:0] mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) mem[i] = init_word(i);
    m_rdata = 32'h0;
    forever begin
      @(posedge clk);
      m_rdata <= mem[widx(m_addr)];
      if (m_we) mem[widx(m_addr)] = m_wdata;
    end
  end

  typedef struct packed {
    logic rst;
    logic cr, cw;
    logic [31:0] ca, cd;
    logic dr, dw, dl;
    logic [31:0] da, dd;
    logic egc, egd;
  } vec_t;

  typedef struct packed {
    logic vld;
    logic own;
    logic [31:0] data;
  } sb_t;

  function automatic vec_t v(
    logic rst, logic cr, logic cw,
    logic [31:0] ca, logic [31:0] cd,
    logic dr, logic dw, logic dl,
    logic [31:0] da, logic [31:0] dd,
    logic egc, logic egd);
    vec_t r;
    r.rst = rst; r.cr = cr; r.cw = cw;
    r.ca = ca; r.cd = cd;
    r.dr = dr; r.dw = dw; r.dl = dl;
    r.da = da; r.dd = dd;
    r.egc = egc; r.egd = egd;
    return r;
  endfunction

  sb_t         sbq[$];
  vec_t        tbl[$];
  logic [31:0] shadow [WORDS];
  logic [31:0] exp_crd, exp_drd;
  int          tests, fails;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input vec_t x);
    sb_t e;
    sb_t n;
    logic ew;
    logic [31:0] ea, ed;
    @(negedge clk);
    reset = x.rst;
    c_req = x.cr; c_we = x.cw;
    c_addr = x.ca; c_wdata = x.cd;
    d_req = x.dr; d_we = x.dw; d_lock = x.dl;
    d_addr = x.da; d_wdata = x.dd;
    #1;
    e = '0;
    if (sbq.size() > 0) e = sbq.pop_front();
    if (x.rst) e.vld = 1'b0;
    ew = 1'b0; ea = 32'h0; ed = 32'h0;
    if (x.egc) begin
      ew = x.cw; ea = x.ca; ed = x.cd;
    end else if (x.egd) begin
      ew = x.dw; ea = x.da; ed = x.dd;
    end
    if (x.rst) begin
      exp_crd = 32'h0;
      exp_drd = 32'h0;
    end else if (e.vld) begin
      if (e.own) exp_drd = e.data;
      else exp_crd = e.data;
    end
    chk({nm, " c_gnt"}, 32'(c_gnt), 32'(x.egc));
    chk({nm, " d_gnt"}, 32'(d_gnt), 32'(x.egd));
    chk({nm, " m_we"}, 32'(m_we), 32'(ew));
    chk({nm, " m_addr"}, m_addr, ea);
    chk({nm, " m_wdata"}, m_wdata, ed);
    chk({nm, " c_rvalid"}, 32'(c_rvalid),
        32'(e.vld && !e.own));
    chk({nm, " d_rvalid"}, 32'(d_rvalid),
        32'(e.vld && e.own));
    chk({nm, " c_rdata"}, c_rdata, exp_crd);
    chk({nm, " d_rdata"}, d_rdata, exp_drd);
    n.vld = (x.egc && !x.cw) || (x.egd && !x.dw);
    n.own = x.egd;
    n.data = shadow[widx(ea)];
    sbq.push_back(n);
    if (ew) shadow[widx(ea)] = ed;
  endtask

  vec_t idle, dl, dlc, rr;

  initial begin
    tests = 0; fails = 0;
    exp_crd = 32'h0; exp_drd = 32'h0;
    for (int i = 0; i < WORDS; i++) shadow[i] = init_word(i);
    reset = 1'b1;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    d_req = 0; d_we = 0; d_lock = 0; d_addr = 0; d_wdata = 0;

    idle = v(0, 0,0,0,0, 0,0,0,0,0, 0,0);
    rr   = v(0, 1,0,32'h10,0, 1,0,0,32'h20,0, 0,0);

    tbl.push_back(v(1, 1,1,32'h8,32'h1, 1,1,1,32'hC,32'h2, 0,0));
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,0, 0,0));
    tbl.push_back(v(0, 1,1,32'h10,32'hDEADBEEF,
                    0,0,0,0,0, 1,0));
    tbl.push_back(v(0, 1,0,32'h10,0, 0,0,0,0,0, 1,0));
    tbl.push_back(idle);
    tbl.push_back(v(1, 0,0,0,0, 0,0,0,0,0, 0,0));
    rr.egc = 1; rr.egd = 0; tbl.push_back(rr);
    rr.egc = 0; rr.egd = 1; tbl.push_back(rr);
    rr.egc = 1; rr.egd = 0; tbl.push_back(rr);
    rr.egc = 0; rr.egd = 1; tbl.push_back(rr);
    tbl.push_back(idle);
    tbl.push_back(v(0, 0,0,0,0,
                    1,1,0,32'h24,32'h12345678, 0,1));
    tbl.push_back(v(0, 0,0,0,0, 1,0,0,32'h24,0, 0,1));
    tbl.push_back(v(0, 1,0,32'h103,0, 0,0,0,0,0, 1,0));
    tbl.push_back(v(0, 1,1,32'h107,32'hCAFE0001,
                    1,1,0,32'h30,32'h0BAD0BAD, 0,1));
    tbl.push_back(v(0, 1,0,32'h107,0, 0,0,0,0,0, 1,0));
    tbl.push_back(v(0, 0,0,0,0, 1,0,0,32'h30,0, 0,1));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    dl  = v(0, 1,0,32'h40,0, 1,0,1,32'h44,0, 0,1);
    dlc = dl; dlc.egc = 1; dlc.egd = 0;
    step("lk_enter", v(0, 0,0,0,0, 1,0,1,32'h44,0, 0,1));
    for (int i = 0; i < MAX_LOCK; i++)
      step($sformatf("lk_d%0d", i), dl);
    step("lk_force", dlc);
    step("lk_resume", dl);
    step("lk_cidle", v(0, 0,0,0,0, 1,0,1,32'h48,0, 0,1));
    for (int i = 0; i < MAX_LOCK; i++)
      step($sformatf("lk2_d%0d", i), dl);
    step("lk2_force", dlc);

    rr = v(0, 1,0,32'h50,0, 1,0,0,32'h54,0, 0,1);
    step("unl_old", rr);
    rr.egc = 1; rr.egd = 0; step("unl_rr_c", rr);
    rr.egc = 0; rr.egd = 1; step("unl_rr_d", rr);
    rr.dl = 1;
    rr.egc = 1; rr.egd = 0; step("relk_c", rr);
    rr.egc = 0; rr.egd = 1; step("relk_d", rr);
    step("relk_hold", rr);
    rr.dl = 0; step("relk_drop", rr);
    rr.egc = 1; rr.egd = 0; step("relk_norm", rr);

    step("mr_dread", v(0, 0,0,0,0, 1,0,0,32'h58,0, 0,1));
    step("mr_reset", v(1, 1,0,32'h5C,0, 1,0,0,32'h58,0, 0,0));
    step("mr_first", v(0, 1,0,32'h5C,0, 1,0,0,32'h58,0, 1,0));
    for (int i = 0; i < 10; i++)
      step($sformatf("idle%0d", i), idle);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter WORDS, default 64, the number of 32-bit data-memory words.
REQ-002 The block SHALL have parameter MAX_LOCK, default 16, the maximum consecutive locked debug grants while the core waits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 c_req, c_we  input  1 each  core access request; write when c_we=1.
REQ-006 c_addr, c_wdata  input  32 each  core byte address and write data.
REQ-007 c_gnt, c_rvalid  output  1 each  core grant; core read data valid.
REQ-008 c_rdata  output  32  core read data.
REQ-009 d_req, d_we, d_lock  input  1 each  debug/loader request, write, burst-lock.
REQ-010 d_addr, d_wdata  input  32 each  debug byte address and write data.
REQ-011 d_gnt, d_rvalid  output  1 each  debug grant; debug read data valid.
REQ-012 d_rdata  output  32  debug read data.
REQ-013 m_we  output  1  memory write enable.
REQ-014 m_addr, m_wdata  output  32 each  memory address and write data.
REQ-015 m_rdata  input  32  memory read data, valid one cycle after m_addr.

Function
REQ-016 Grants SHALL be combinational in the request cycle; at most one of c_gnt/d_gnt SHALL be 1.
REQ-017 The granted requester's we/addr/wdata SHALL drive m_we/m_addr/m_wdata; with no grant, all three SHALL be 0.
REQ-018 A granted write SHALL commit at that cycle's clock edge; no rvalid SHALL follow a write.
REQ-019 A granted read SHALL produce rvalid=1 for exactly one cycle on the owner's port, the cycle after grant, with rdata=m_rdata.
REQ-020 rdata SHALL hold its last value when rvalid=0; the non-owner's rdata SHALL not change.
REQ-021 Simultaneous requests in state NORMAL SHALL be granted round-robin to the requester not granted last; the last-winner register SHALL reset to debug, so the core wins first.
REQ-022 A lone requester SHALL be granted every cycle it requests.
REQ-023 FSM states SHALL be NORMAL and LOCKED.
REQ-024 NORMAL->LOCKED SHALL occur when d_gnt=1 and d_lock=1.
REQ-025 In LOCKED, only debug SHALL be granted, and the lock counter SHALL increment per debug grant while c_req=1.
REQ-026 In LOCKED, the counter SHALL clear on any cycle with c_req=0.
REQ-027 When the counter reaches MAX_LOCK with c_req=1, the core SHALL receive one forced grant, the counter SHALL clear, and the FSM SHALL stay LOCKED.
REQ-028 LOCKED->NORMAL SHALL occur at the edge of any cycle with d_lock=0.
REQ-029 A request arriving in the same cycle as the transition SHALL be arbitrated under the old state.
REQ-030 Address bits [1:0] SHALL pass through unmodified.
REQ-031 Addresses at or above 4*WORDS SHALL still be forwarded; range checking SHALL be the memory's responsibility.

Reset
REQ-032 Reset SHALL force c_gnt, d_gnt, c_rvalid, d_rvalid, m_we, m_addr and m_wdata to 0, and c_rdata and d_rdata to 0.
REQ-033 Reset SHALL set the FSM to NORMAL, the lock counter to 0 and the last-winner to debug.
REQ-034 Reset asserted mid-operation SHALL drop any pending read response and SHALL commit no write in that cycle.

Structure
REQ-035 Package dmem_arb_pkg SHALL hold the state encoding, the requester IDs (CORE=0, DBG=1) and the default WORDS/MAX_LOCK constants.
REQ-036 Two-way round-robin selection SHALL be sub-module dmem_rr_pick (inputs req[1:0], last; output gnt[1:0]).

Verification
REQ-037 Core-only test: core writes 0xDEADBEEF to 0x10, then reads 0x10 -> c_gnt=1 both cycles; c_rvalid=1 the next cycle with c_rdata=0xDEADBEEF; d_* outputs stay 0.
REQ-038 Contention test: both request reads for 4 cycles after reset -> grants alternate core, debug, core, debug; each rvalid lands on its owner one cycle later.
REQ-039 Lock-starvation test: debug holds d_lock=1 with continuous reads while c_req=1 (MAX_LOCK=16) -> 16 d_gnt cycles, 1 c_gnt cycle, then debug resumes.
REQ-040 Unlock test: d_lock falls -> FSM returns to NORMAL next cycle and round-robin resumes.
REQ-041 Mid-read reset test: reset asserted in the cycle after a debug read grant -> d_rvalid=0 and all outputs 0 that cycle; the first grant after reset goes to the core.
REQ-042 Idle test: no requests for 10 cycles -> m_we, m_addr and m_wdata stay 0; no rvalid asserted.
